// File: rtl/cpu_pkg.sv
// Shared types and widths for the CPU fetch front end.
// Latency: none (declarations only).
// Backpressure: not applicable.
package cpu_pkg;

    localparam int INSTR_W      = 32;
    localparam int JUMP_FIELD_W = 26;
    localparam int IMM_W        = 16;

    // Fetch FSM encoding: REQ reads memory, HOLD offers to decode, DROP drains a squashed read.
    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_HOLD = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/next_pc_calc.sv
// Rebuilds jump/branch byte targets from decode fields and forms the sequential PC.
// Latency: purely combinational.
// Backpressure: none; outputs are meaningful only in the cycle a redirect or transfer happens.
module next_pc_calc
    import cpu_pkg::*;
(
    input  logic [INSTR_W-1:0]      base_i,
    input  logic [INSTR_W-1:0]      pc_i,
    input  logic                    jump_i,
    input  logic [JUMP_FIELD_W-1:0] jump_target_i,
    input  logic                    branch_i,
    input  logic [IMM_W-1:0]        branch_offset_i,
    output logic [INSTR_W-1:0]      target_o,
    output logic [INSTR_W-1:0]      seq_pc_o
);

    logic [INSTR_W-1:0] jump_tgt;
    logic [INSTR_W-1:0] branch_tgt;
    logic [INSTR_W-1:0] branch_disp;

    // Target selection: jump beats branch; with neither, the target falls back to pc_i.
    always_comb begin
        jump_tgt    = {base_i[INSTR_W-1:INSTR_W-4], jump_target_i, 2'b00};
        branch_disp = {{(INSTR_W-IMM_W-2){branch_offset_i[IMM_W-1]}}, branch_offset_i, 2'b00};
        branch_tgt  = base_i + branch_disp;
        seq_pc_o    = pc_i + 32'd4;
        if (jump_i) begin
            target_o = jump_tgt;
        end else if (branch_i) begin
            target_o = branch_tgt;
        end else begin
            target_o = pc_i;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch front end: owns the PC, reads instruction memory by word index, hands words to decode.
// Latency: ack -> instr_valid_o next cycle; transfer -> imem_req_o next cycle (1 instr / 2 cycles).
// Backpressure: holds instr_o/pc_o with imem_req_o low until decode is ready; redirects squash.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IDX_W    = 30
) (
    input  logic              clk_i,
    input  logic              rst_i,
    output logic              imem_req_o,
    output logic [IDX_W-1:0]  imem_addr_o,
    input  logic              imem_ack_i,
    input  logic [31:0]       imem_data_i,
    output logic [31:0]       instr_o,
    output logic [31:0]       pc_o,
    output logic              instr_valid_o,
    input  logic              instr_ready_i,
    input  logic              jump_i,
    input  logic [25:0]       jump_target_i,
    input  logic              branch_i,
    input  logic [15:0]       branch_offset_i
);

    fetch_state_e       state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        last_pc_q, last_pc_d;
    logic [31:0]        instr_q, instr_d;
    logic [31:0]        pc_out_q, pc_out_d;
    logic [IDX_W-1:0]   req_idx_q, req_idx_d;

    logic [31:0]        base;
    logic [31:0]        target;
    logic [31:0]        seq_pc;
    logic               redirect;

    assign base     = last_pc_q + 32'd4;
    assign redirect = jump_i | branch_i;

    next_pc_calc u_next_pc_calc (
        .base_i          (base),
        .pc_i            (pc_out_q),
        .jump_i          (jump_i),
        .jump_target_i   (jump_target_i),
        .branch_i        (branch_i),
        .branch_offset_i (branch_offset_i),
        .target_o        (target),
        .seq_pc_o        (seq_pc)
    );

    // Next-state and datapath updates; every register holds unless a case below moves it.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        last_pc_d = last_pc_q;
        instr_d   = instr_q;
        pc_out_d  = pc_out_q;
        req_idx_d = req_idx_q;
        case (state_q)
            ST_REQ: begin
                // Latch the index in flight so a redirect cannot disturb the outstanding read.
                req_idx_d = pc_q[IDX_W+1:2];
                if (redirect) begin
                    pc_d    = target;
                    state_d = imem_ack_i ? ST_REQ : ST_DROP;
                end else if (imem_ack_i) begin
                    instr_d  = imem_data_i;
                    pc_out_d = pc_q;
                    state_d  = ST_HOLD;
                end
            end
            ST_DROP: begin
                // Later redirects overwrite the pending target; the squashed data is never used.
                if (redirect) begin
                    pc_d = target;
                end
                if (imem_ack_i) begin
                    state_d = ST_REQ;
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    pc_d    = target;
                    state_d = ST_REQ;
                end else if (instr_ready_i) begin
                    last_pc_d = pc_out_q;
                    pc_d      = seq_pc;
                    state_d   = ST_REQ;
                end
            end
            default: begin
                state_d = ST_REQ;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_REQ;
            pc_q      <= RESET_PC;
            last_pc_q <= RESET_PC - 32'd4;
            instr_q   <= 32'd0;
            pc_out_q  <= 32'd0;
            req_idx_q <= RESET_PC[IDX_W+1:2];
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            last_pc_q <= last_pc_d;
            instr_q   <= instr_d;
            pc_out_q  <= pc_out_d;
            req_idx_q <= req_idx_d;
        end
    end

    // Outputs come straight from registers: no input reaches them combinationally.
    assign imem_req_o    = (state_q != ST_HOLD);
    assign instr_valid_o = (state_q == ST_HOLD);
    assign imem_addr_o   = (state_q == ST_DROP) ? req_idx_q : pc_q[IDX_W+1:2];
    assign instr_o       = instr_q;
    assign pc_o          = pc_out_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed redirect/stall/reset scenarios against a latency-programmable memory.
// Latency: memory acks after a programmable number of wait cycles.
// Backpressure: decode ready driven per scenario; transfers checked by a scoreboard monitor.
module tb_instr_fetch_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        imem_req_o;
    logic [29:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_data_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic        jump_i;
    logic [25:0] jump_target_i;
    logic        branch_i;
    logic [15:0] branch_offset_i;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } xfer_t;

    xfer_t exp_q[$];
    int    n_checks  = 0;
    int    n_fail    = 0;
    int    xfer_cnt  = 0;
    int    ack_delay = 1;
    int    wait_cnt  = 0;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .IDX_W(30)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .imem_req_o      (imem_req_o),
        .imem_addr_o     (imem_addr_o),
        .imem_ack_i      (imem_ack_i),
        .imem_data_i     (imem_data_i),
        .instr_o         (instr_o),
        .pc_o            (pc_o),
        .instr_valid_o   (instr_valid_o),
        .instr_ready_i   (instr_ready_i),
        .jump_i          (jump_i),
        .jump_target_i   (jump_target_i),
        .branch_i        (branch_i),
        .branch_offset_i (branch_offset_i)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] mem_word(input logic [29:0] idx);
        return {2'b10, idx} ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    // Instruction memory: acks once a request has waited ack_delay cycles.
    initial begin
        imem_ack_i  = 1'b0;
        imem_data_i = 32'd0;
        forever begin
            @(posedge clk_i);
            #1;
            if (rst_i) begin
                imem_ack_i = 1'b0;
                wait_cnt   = 0;
            end else if (imem_req_o && wait_cnt >= ack_delay) begin
                imem_ack_i  = 1'b1;
                imem_data_i = mem_word(imem_addr_o);
                wait_cnt    = 0;
            end else begin
                imem_ack_i  = 1'b0;
                imem_data_i = 32'hBAD0_BAD0;
                if (imem_req_o) wait_cnt++;
            end
        end
    end

    // Scoreboard monitor: every real transfer must match the oldest expected instruction.
    initial begin
        xfer_t e;
        forever begin
            @(negedge clk_i);
            if (!rst_i && instr_valid_o && instr_ready_i && !jump_i && !branch_i) begin
                xfer_cnt++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_xfer: pc_o %h instr_o %h, nothing expected", pc_o, instr_o);
                end else begin
                    e = exp_q.pop_front();
                    chk("xfer_pc", pc_o, e.pc);
                    chk("xfer_instr", instr_o, e.instr);
                end
            end
        end
    end

    task automatic wait_valid(input string name);
        int n = 0;
        while (!instr_valid_o && n < 60) begin
            cyc();
            n++;
        end
        chk({name, "_valid_seen"}, {31'd0, instr_valid_o}, 32'd1);
    endtask

    task automatic accept_one(input logic [31:0] pc);
        exp_q.push_back('{pc, mem_word(pc[31:2])});
        wait_valid("accept");
        instr_ready_i = 1'b1;
        cyc();
        instr_ready_i = 1'b0;
    endtask

    task automatic redirect(input bit is_jump, input logic [25:0] jt, input logic [15:0] off);
        if (is_jump) begin
            jump_i        = 1'b1;
            jump_target_i = jt;
        end else begin
            branch_i        = 1'b1;
            branch_offset_i = off;
        end
        cyc();
        jump_i   = 1'b0;
        branch_i = 1'b0;
    endtask

    task automatic pulse_reset(input string tag);
        rst_i = 1'b1;
        cyc();
        rst_i = 1'b0;
        chk({tag, "_valid"}, {31'd0, instr_valid_o}, 32'd0);
        chk({tag, "_req"}, {31'd0, imem_req_o}, 32'd1);
        chk({tag, "_addr"}, {2'b00, imem_addr_o}, 32'd0);
        chk({tag, "_instr"}, instr_o, 32'd0);
        chk({tag, "_pc"}, pc_o, 32'd0);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached with %0d checks, %0d failures", n_checks, n_fail);
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        int n;
        int cnt0;
        rst_i           = 1'b1;
        instr_ready_i   = 1'b0;
        jump_i          = 1'b0;
        jump_target_i   = 26'd0;
        branch_i        = 1'b0;
        branch_offset_i = 16'd0;

        // Reset state.
        cyc();
        cyc();
        chk("rst_req", {31'd0, imem_req_o}, 32'd1);
        chk("rst_valid", {31'd0, instr_valid_o}, 32'd0);
        chk("rst_addr", {2'b00, imem_addr_o}, 32'd0);
        chk("rst_instr", instr_o, 32'd0);
        chk("rst_pc", pc_o, 32'd0);

        // Sequential fetch with ready held high.
        for (int i = 0; i < 4; i++) exp_q.push_back('{32'(i * 4), mem_word(30'(i))});
        rst_i         = 1'b0;
        instr_ready_i = 1'b1;
        n = 0;
        while (xfer_cnt < 4 && n < 100) begin
            cyc();
            n++;
        end
        instr_ready_i = 1'b0;
        chk("seq_xfers", xfer_cnt, 32'd4);

        // Jump from a squashed 0x10 to 0x0040_0010, then jump from last_pc=0x0040_0010.
        wait_valid("hold_0x10");
        chk("hold_pc_0x10", pc_o, 32'h0000_0010);
        redirect(1'b1, 26'h010_0004, 16'd0);
        chk("jump1_addr", {2'b00, imem_addr_o}, 32'h0010_0004);
        accept_one(32'h0040_0010);
        wait_valid("hold_0x400014");
        redirect(1'b1, 26'h010_0008, 16'd0);
        chk("jump2_addr", {2'b00, imem_addr_o}, 32'h0010_0008);
        chk("jump2_req", {31'd0, imem_req_o}, 32'd1);
        accept_one(32'h0040_0020);

        // Jump back to 0x8, then a backward branch loop on 0x8.
        wait_valid("hold_0x400024");
        redirect(1'b1, 26'd2, 16'd0);
        chk("jump3_addr", {2'b00, imem_addr_o}, 32'd2);
        accept_one(32'h0000_0008);
        for (int i = 0; i < 2; i++) begin
            wait_valid("hold_0xc");
            redirect(1'b0, 26'd0, 16'hFFFF);
            chk("loop_addr", {2'b00, imem_addr_o}, 32'd2);
            accept_one(32'h0000_0008);
        end

        // Branch to the top word, then sequential wrap to 0.
        wait_valid("hold_0xc_wrap");
        redirect(1'b0, 26'd0, 16'hFFFC);
        chk("wrap_addr", {2'b00, imem_addr_o}, 32'h3FFF_FFFF);
        accept_one(32'hFFFF_FFFC);
        ack_delay = 3;
        accept_one(32'h0000_0000);

        // Jump in the first wait cycle of a slow read: index frozen until the stale ack.
        redirect(1'b1, 26'h40, 16'd0);
        for (int i = 0; i < 3; i++) begin
            chk("drop_addr", {2'b00, imem_addr_o}, 32'd1);
            chk("drop_req", {31'd0, imem_req_o}, 32'd1);
            chk("drop_valid", {31'd0, instr_valid_o}, 32'd0);
            cyc();
        end
        chk("after_drop_addr", {2'b00, imem_addr_o}, 32'h40);
        chk("after_drop_valid", {31'd0, instr_valid_o}, 32'd0);
        accept_one(32'h0000_0100);

        // Decode stalls 5 cycles in HOLD, then exactly one transfer.
        wait_valid("stall");
        for (int i = 0; i < 5; i++) begin
            chk("stall_instr", instr_o, mem_word(30'h41));
            chk("stall_pc", pc_o, 32'h0000_0104);
            chk("stall_req", {31'd0, imem_req_o}, 32'd0);
            cyc();
        end
        cnt0 = xfer_cnt;
        accept_one(32'h0000_0104);
        repeat (6) cyc();
        chk("stall_single_xfer", xfer_cnt, cnt0 + 1);

        // Reset during HOLD and during a REQ wait.
        wait_valid("pre_rst_hold");
        pulse_reset("rst_hold");
        cyc();
        chk("pre_rst_req_wait", {31'd0, imem_req_o & ~instr_valid_o}, 32'd1);
        pulse_reset("rst_req");
        accept_one(32'h0000_0000);

        repeat (3) cyc();
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
